mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 130 +++++++++++++
 tb/tb_mem_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Byte-stream image loader: packs incoming bytes big-endian into 32-bit words
// and writes each word to a data RAM in a single WRITE cycle.
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] byte_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [31:0] MAX_LIMIT = 32'(MAX_BYTES);

  state_t      state;
  state_t      state_next;
  logic [31:0] word_ptr;
  logic [31:0] acc_data;
  logic [3:0]  acc_sel;
  logic [31:0] cnt_q;
  logic        finish_load;

  logic        accept;
  logic [1:0]  lane;
  logic [1:0]  lane_pos;
  logic        hit_max;
  logic        term;
  logic        restart;

  // Handshake: a byte transfers on a rising edge where byte_valid and
  // byte_ready are both 1; the source must hold the byte until then.
  assign accept   = (state == COLLECT) && byte_valid;
  assign lane     = cnt_q[1:0];
  assign lane_pos = ~lane;
  assign hit_max  = (cnt_q + 32'd1) == MAX_LIMIT;
  assign term     = accept && ((lane == 2'd3) || byte_last || hit_max);
  assign restart  = start && ((state == IDLE) || (state == DONE));

  assign ram_addr = word_ptr;
  assign byte_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (term) state_next = WRITE;
      WRITE:   state_next = finish_load ? DONE : COLLECT;
      DONE:    if (start) state_next = COLLECT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_sel    = 4'b0000;
    ram_data   = 32'd0;
    case (state)
      COLLECT: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        busy     = 1'b1;
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_sel  = acc_sel;
        ram_data = acc_data;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Lane 0 lands in bits 31:24, so the byte slot index is the inverted lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_ptr    <= BASE_ADDR;
      acc_data    <= 32'd0;
      acc_sel     <= 4'b0000;
      cnt_q       <= 32'd0;
      finish_load <= 1'b0;
    end else if (restart) begin
      word_ptr    <= BASE_ADDR;
      acc_data    <= 32'd0;
      acc_sel     <= 4'b0000;
      cnt_q       <= 32'd0;
      finish_load <= 1'b0;
    end else if (accept) begin
      acc_data[{lane_pos, 3'b000} +: 8] <= byte_data;
      acc_sel[lane_pos]                 <= 1'b1;
      cnt_q                             <= cnt_q + 32'd1;
      finish_load                       <= byte_last || hit_max;
    end else if (state == WRITE) begin
      word_ptr <= word_ptr + 32'd4;
      acc_data <= 32'd0;
      acc_sel  <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: word packing, partial words, byte limit,
// mid-load reset, start filtering and valid/ready hold-off.
module tb_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXB = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_data;
  logic        busy;
  logic        done;
  logic [31:0] byte_cnt;

  int checks   = 0;
  int failures = 0;

  logic [67:0] wr_q[$];
  logic [67:0] exp_q[$];

  mem_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_data(ram_data),
    .busy(busy), .done(done), .byte_cnt(byte_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // every RAM write observed, as {addr, sel, data}
  always @(negedge clk) begin
    if (ram_we) wr_q.push_back({ram_addr, ram_sel, ram_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks; all are entered and left at a falling edge
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int waited;
    waited     = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    while (!byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_byte_timeout: byte %h not accepted, byte_ready=%b expected 1", d, byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 6 && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b1; byte_data = 8'h99; byte_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, busy, done, ram_ce, ram_we, ram_sel, ram_data, byte_cnt, ram_addr} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, BASE}) begin
      failures++;
      $display("FAIL reset_outputs: rdy=%b busy=%b done=%b ce=%b we=%b sel=%h data=%h cnt=%0d addr=%h, expected all 0 and addr=%h",
               byte_ready, busy, done, ram_ce, ram_we, ram_sel, ram_data, byte_cnt, ram_addr, BASE);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_not_ready: byte_ready=%b busy=%b, expected 0 0", byte_ready, busy);
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_single_word();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({BASE, 4'hF, 32'h12345678});
    pulse_start();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b1);
    checks++;
    if ({ram_ce, ram_we, ram_addr, ram_sel, ram_data} !== {1'b1, 1'b1, BASE, 4'hF, 32'h12345678}) begin
      failures++;
      $display("FAIL single_write_latency: ce=%b we=%b addr=%h sel=%h data=%h, expected 1 1 %h f 12345678",
               ram_ce, ram_we, ram_addr, ram_sel, ram_data, BASE);
    end
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_write_flags: busy=%b byte_ready=%b, expected 1 0", busy, byte_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || byte_cnt !== 32'd4) begin
      failures++;
      $display("FAIL single_done: done=%b busy=%b cnt=%0d, expected 1 0 4", done, busy, byte_cnt);
    end
    @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL single_write_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL single_write_%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_two_words();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({BASE, 4'hF, 32'hAABBCCDD});
    exp_q.push_back({BASE + 32'd4, 4'hC, 32'hEEFF0000});
    pulse_start();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b1);
    wait_done();
    checks++;
    if (done !== 1'b1 || byte_cnt !== 32'd6) begin
      failures++;
      $display("FAIL two_words_done: done=%b cnt=%0d, expected 1 6", done, byte_cnt);
    end
    @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL two_words_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL two_words_write_%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_max_bytes();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({BASE, 4'hF, 32'h10111213});
    exp_q.push_back({BASE + 32'd4, 4'hF, 32'h14151617});
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'h18 + 8'(i);
      checks++;
      if (byte_ready !== 1'b0) begin
        failures++;
        $display("FAIL max_ready_low_%0d: byte_ready=%b, expected 0", i, byte_ready);
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || byte_cnt !== 32'd8) begin
      failures++;
      $display("FAIL max_done: done=%b cnt=%0d, expected 1 8", done, byte_cnt);
    end
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL max_write_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL max_write_%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({BASE, 4'hF, 32'h01020304});
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({byte_ready, busy, done, ram_ce, ram_we, ram_sel, ram_data, byte_cnt, ram_addr} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, BASE}) begin
      failures++;
      $display("FAIL async_reset: rdy=%b busy=%b done=%b ce=%b we=%b sel=%h data=%h cnt=%0d addr=%h, expected all 0 and addr=%h",
               byte_ready, busy, done, ram_ce, ram_we, ram_sel, ram_data, byte_cnt, ram_addr, BASE);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({BASE, 4'hF, 32'h21222324});
    pulse_start();
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'h24, 1'b1);
    wait_done();
    checks++;
    if (done !== 1'b1 || byte_cnt !== 32'd4) begin
      failures++;
      $display("FAIL reset_reload_done: done=%b cnt=%0d, expected 1 4", done, byte_cnt);
    end
    @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_write_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_write_%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_filter();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({BASE, 4'hF, 32'h31323334});
    exp_q.push_back({BASE, 4'h8, 32'h35000000});
    pulse_start();
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    pulse_start();
    checks++;
    if (byte_cnt !== 32'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_in_collect: cnt=%0d busy=%b, expected 2 1", byte_cnt, busy);
    end
    send_byte(8'h33, 1'b0);
    send_byte(8'h34, 1'b1);
    wait_done();
    checks++;
    if (done !== 1'b1 || ram_addr !== BASE + 32'd4) begin
      failures++;
      $display("FAIL done_pointer: done=%b addr=%h, expected 1 %h", done, ram_addr, BASE + 32'd4);
    end
    pulse_start();
    checks++;
    if (done !== 1'b0 || byte_cnt !== 32'd0 || ram_addr !== BASE || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_in_done: done=%b cnt=%0d addr=%h busy=%b, expected 0 0 %h 1",
               done, byte_cnt, ram_addr, busy, BASE);
    end
    send_byte(8'h35, 1'b1);
    wait_done();
    @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL start_write_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL start_write_%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_valid_toggle();
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({BASE, 4'hF, 32'hA1A2A3A4});
    exp_q.push_back({BASE + 32'd4, 4'h8, 32'hB1000000});
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hA1 + 8'(i), 1'b0);
      byte_data = 8'h5A;
      @(negedge clk);
    end
    send_byte(8'hA4, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'hB1;
    byte_last  = 1'b1;
    checks++;
    if (byte_ready !== 1'b0 || ram_we !== 1'b1 || ram_data !== 32'hA1A2A3A4) begin
      failures++;
      $display("FAIL hold_during_write: rdy=%b we=%b data=%h, expected 0 1 a1a2a3a4",
               byte_ready, ram_we, ram_data);
    end
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1 || byte_cnt !== 32'd4) begin
      failures++;
      $display("FAIL ready_after_write: rdy=%b cnt=%0d, expected 1 4", byte_ready, byte_cnt);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    wait_done();
    checks++;
    if (done !== 1'b1 || byte_cnt !== 32'd5) begin
      failures++;
      $display("FAIL toggle_done: done=%b cnt=%0d, expected 1 5", done, byte_cnt);
    end
    @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL toggle_write_count: got %0d writes, expected %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL toggle_write_%0d: got %h, expected %h", i, wr_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    test_reset();
    test_single_word();
    test_two_words();
    test_max_bytes();
    test_reset_mid_load();
    test_start_filter();
    test_valid_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
